alu_flags: RTL

//  Status/flag stage directly downstream of the ALU. Latches Z/N/C/V from each
//  ALU result, feeds the registered carry back to the ALU's carry-in for

---
 rtl/alu_flags.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_flags.sv
// ---------------------------------------------------------------------------
// alu_flags
// Status/flag stage that sits after the ALU. It captures Z/N/C/V from each
// ALU result and returns the registered carry to the ALU for multi-byte
// arithmetic. It also evaluates jump conditions for the control unit and
// keeps a small LIFO of flag snapshots for call/interrupt save and restore.
// Flag vector layout: flags = {V, C, N, Z}.
// ---------------------------------------------------------------------------
module alu_flags #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_over,
    input  logic       alu_cmp,
    input  logic       alu_oe,
    input  logic       flag_we,
    input  logic       carry_clr,
    input  logic       cond_valid,
    input  logic [3:0] cond_sel,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] flags,
    output logic       carry_to_alu,
    output logic       jump_taken,
    output logic       jump_valid,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    // Bit positions inside the flag vector.
    localparam int FZ = 0;
    localparam int FN = 1;
    localparam int FC = 2;
    localparam int FV = 3;

    // The stack pointer counts entries, so it needs one bit more than the
    // memory index in order to represent the "completely full" state.
    localparam int IDXW = $clog2(STACK_DEPTH);
    localparam int SPW  = IDXW + 1;

    localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
    localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    // Condition codes used by the control unit.
    localparam logic [3:0] CC_ALWAYS = 4'd0;
    localparam logic [3:0] CC_Z      = 4'd1;
    localparam logic [3:0] CC_NZ     = 4'd2;
    localparam logic [3:0] CC_C      = 4'd3;
    localparam logic [3:0] CC_NC     = 4'd4;
    localparam logic [3:0] CC_N      = 4'd5;
    localparam logic [3:0] CC_NN     = 4'd6;
    localparam logic [3:0] CC_V      = 4'd7;
    localparam logic [3:0] CC_NV     = 4'd8;
    localparam logic [3:0] CC_UGT    = 4'd9;
    localparam logic [3:0] CC_SLT    = 4'd10;
    localparam logic [3:0] CC_SGE    = 4'd11;
    localparam logic [3:0] CC_SGT    = 4'd12;
    localparam logic [3:0] CC_SLE    = 4'd13;
    localparam logic [3:0] CC_ULE    = 4'd14;
    localparam logic [3:0] CC_NEVER  = 4'd15;

    // Evaluate one condition code against a flag snapshot.
    function automatic logic eval_cond(input logic [3:0] sel, input logic [3:0] f);
        logic z;
        logic n;
        logic c;
        logic v;
        logic r;
        z = f[FZ];
        n = f[FN];
        c = f[FC];
        v = f[FV];
        case (sel)
            CC_ALWAYS: r = 1'b1;
            CC_Z:      r = z;
            CC_NZ:     r = ~z;
            CC_C:      r = c;
            CC_NC:     r = ~c;
            CC_N:      r = n;
            CC_NN:     r = ~n;
            CC_V:      r = v;
            CC_NV:     r = ~v;
            CC_UGT:    r = c & ~z;
            CC_SLT:    r = n ^ v;
            CC_SGE:    r = ~(n ^ v);
            CC_SGT:    r = ~z & ~(n ^ v);
            CC_SLE:    r = z | (n ^ v);
            CC_ULE:    r = ~c | z;
            CC_NEVER:  r = 1'b0;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Registered state.
    logic [3:0]     flags_r;
    logic           jump_taken_r;
    logic           jump_valid_r;
    logic           stack_err_r;
    logic [SPW-1:0] sp_r;
    logic [3:0]     mem_r [STACK_DEPTH];

    // Combinational next-state values.
    logic           upd_s;
    logic           full_s;
    logic           empty_s;
    logic           push_ok_s;
    logic           pop_ok_s;
    logic           op_err_s;
    logic [SPW-1:0] sp_m1_s;
    logic [SPW-1:0] sp_nxt_s;
    logic [3:0]     top_s;
    logic [3:0]     flags_nxt_s;
    logic           cond_s;

    assign full_s  = (sp_r == SP_FULL);
    assign empty_s = (sp_r == SP_ZERO);
    assign sp_m1_s = sp_r - SP_ONE;
    assign top_s   = mem_r[sp_m1_s[IDXW-1:0]];

    // Classify this cycle's stack request as push, pop, illegal or idle.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        op_err_s  = 1'b0;
        sp_nxt_s  = sp_r;
        if (push && pop) begin
            op_err_s = 1'b1;
        end else if (push) begin
            if (full_s) begin
                op_err_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
                sp_nxt_s  = sp_r + SP_ONE;
            end
        end else if (pop) begin
            if (empty_s) begin
                op_err_s = 1'b1;
            end else begin
                pop_ok_s = 1'b1;
                sp_nxt_s = sp_m1_s;
            end
        end else begin
            sp_nxt_s = sp_r;
        end
    end

    // Next flag value: a restoring pop overrides everything, carry_clr
    // overrides only C, and an ALU update otherwise refreshes all four.
    always_comb begin
        upd_s       = alu_oe & (flag_we | alu_cmp);
        flags_nxt_s = flags_r;
        if (pop_ok_s) begin
            flags_nxt_s = top_s;
        end else begin
            if (upd_s) begin
                flags_nxt_s[FZ] = (alu_out == 8'h00);
                flags_nxt_s[FN] = alu_out[7];
                flags_nxt_s[FC] = alu_carry;
                flags_nxt_s[FV] = alu_over;
            end else begin
                flags_nxt_s = flags_r;
            end
            if (carry_clr) begin
                flags_nxt_s[FC] = 1'b0;
            end else begin
                flags_nxt_s[FC] = flags_nxt_s[FC];
            end
        end
    end

    // Condition result is taken from the flags registered before this edge,
    // so a same-cycle flag update never influences the evaluation.
    always_comb begin
        cond_s = eval_cond(cond_sel, flags_r);
    end

    // Flag, stack pointer, jump and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r      <= 4'b0000;
            sp_r         <= SP_ZERO;
            jump_taken_r <= 1'b0;
            jump_valid_r <= 1'b0;
            stack_err_r  <= 1'b0;
        end else begin
            flags_r     <= flags_nxt_s;
            sp_r        <= sp_nxt_s;
            stack_err_r <= op_err_s;
            if (cond_valid) begin
                jump_taken_r <= cond_s;
                jump_valid_r <= 1'b1;
            end else begin
                jump_taken_r <= jump_taken_r;
                jump_valid_r <= 1'b0;
            end
        end
    end

    // Stack storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[sp_r[IDXW-1:0]] <= flags_r;
        end
    end

    assign flags        = flags_r;
    assign carry_to_alu = flags_r[FC];
    assign jump_taken   = jump_taken_r;
    assign jump_valid   = jump_valid_r;
    assign stack_full   = full_s;
    assign stack_empty  = empty_s;
    assign stack_err    = stack_err_r;

endmodule
